// File: rtl/myproject_mul_share.sv
// myproject_mul_share
// Shares one signed DIN0_WIDTH x DIN1_WIDTH multiplier among N_REQ requesters.
// A round-robin arbiter feeds a two-stage pipeline. S1 captures the operands
// and the requester tag. S2 holds the truncated product and drives rsp_*.
// Back-pressure from rsp_ready stalls S2, then S1, and only then the requesters.
module myproject_mul_share #(
  parameter int N_REQ      = 4,
  parameter int DIN0_WIDTH = 18,
  parameter int DIN1_WIDTH = 18,
  parameter int DOUT_WIDTH = 30,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ*DIN0_WIDTH-1:0]      req_a,
  input  logic [N_REQ*DIN1_WIDTH-1:0]      req_b,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [DOUT_WIDTH-1:0]            rsp_data,
  output logic                             busy
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  // Arbitration state: the index of the requester that transferred last.
  logic [ID_W-1:0]       ptr_r;

  // Stage 1: operands and tag.
  logic                  s1_v_r;
  logic [DIN0_WIDTH-1:0] s1_a_r;
  logic [DIN1_WIDTH-1:0] s1_b_r;
  logic [ID_W-1:0]       s1_id_r;

  // Stage 2: product and tag.
  logic                  s2_v_r;
  logic [ID_W-1:0]       s2_id_r;
  logic [DOUT_WIDTH-1:0] s2_data_r;

  // Combinational helpers.
  logic [N_REQ-1:0]      grant_s;
  logic                  any_s;
  logic [ID_W-1:0]       gidx_s;
  logic [ID_W-1:0]       cand_s;
  logic                  s1_adv_s;
  logic                  s2_adv_s;
  logic                  xfer_s;
  logic [DIN0_WIDTH-1:0] sel_a_s;
  logic [DIN1_WIDTH-1:0] sel_b_s;
  logic [PW-1:0]         ext_a_s;
  logic [PW-1:0]         ext_b_s;
  logic [PW-1:0]         prod_s;

  // Round-robin search over req_valid, starting just after the last winner.
  always_comb begin
    any_s   = 1'b0;
    gidx_s  = '0;
    cand_s  = '0;
    grant_s = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand_s = ID_W'((int'(ptr_r) + off) % N_REQ);
      if (!any_s && req_valid[cand_s]) begin
        any_s  = 1'b1;
        gidx_s = cand_s;
      end else begin
        any_s  = any_s;
      end
    end
    if (any_s) begin
      grant_s[gidx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Stall chain, handshake, operand mux and the shared multiplier.
  always_comb begin
    s2_adv_s  = !s2_v_r || rsp_ready;
    s1_adv_s  = !s1_v_r || s2_adv_s;
    xfer_s    = any_s && s1_adv_s && ap_rst_n;
    req_ready = grant_s & {N_REQ{s1_adv_s && ap_rst_n}};
    sel_a_s   = req_a[gidx_s*DIN0_WIDTH +: DIN0_WIDTH];
    sel_b_s   = req_b[gidx_s*DIN1_WIDTH +: DIN1_WIDTH];
    // Sign-extend both operands to the full product width; the low PW bits of
    // the unsigned product then equal the two's-complement signed product.
    ext_a_s   = {{DIN1_WIDTH{s1_a_r[DIN0_WIDTH-1]}}, s1_a_r};
    ext_b_s   = {{DIN0_WIDTH{s1_b_r[DIN1_WIDTH-1]}}, s1_b_r};
    prod_s    = ext_a_s * ext_b_s;
    busy      = s1_v_r || s2_v_r;
  end

  // Arbitration pointer: moves only when a pair is actually handed over.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_r <= ID_W'(N_REQ - 1);
    end else if (xfer_s) begin
      ptr_r <= gidx_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Stage 1 register: captures the granted operands whenever it may advance.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_v_r  <= 1'b0;
      s1_a_r  <= '0;
      s1_b_r  <= '0;
      s1_id_r <= '0;
    end else if (s1_adv_s) begin
      s1_v_r  <= xfer_s;
      s1_a_r  <= sel_a_s;
      s1_b_r  <= sel_b_s;
      s1_id_r <= gidx_s;
    end else begin
      s1_v_r  <= s1_v_r;
    end
  end

  // Stage 2 register: truncated product, held while downstream stalls.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s2_v_r    <= 1'b0;
      s2_id_r   <= '0;
      s2_data_r <= '0;
    end else if (s2_adv_s) begin
      s2_v_r    <= s1_v_r;
      s2_id_r   <= s1_id_r;
      s2_data_r <= prod_s[DOUT_WIDTH-1:0];
    end else begin
      s2_v_r    <= s2_v_r;
    end
  end

  assign rsp_valid = s2_v_r;
  assign rsp_id    = s2_id_r;
  assign rsp_data  = s2_data_r;

endmodule

// File: doc/myproject_mul_share.md
# myproject_mul_share

Time-multiplexes one signed DIN0_WIDTH x DIN1_WIDTH multiplier across N_REQ requesters. Each requester issues operand pairs with a valid/ready handshake. A round-robin arbiter grants one pair per cycle into a 2-stage pipeline, and the truncated product returns tagged with the requester index. The block sits between dense/conv layer engines and the shared DSP when the layer reuse factor is greater than 1.

## Interface
- N_REQ, 4: number of requesters (2..8).
- DIN0_WIDTH, 18: signed operand A width.
- DIN1_WIDTH, 18: signed operand B width.
- DOUT_WIDTH, 30: result width, no greater than DIN0_WIDTH+DIN1_WIDTH.
- ID_W, $clog2(N_REQ): width of the requester tag.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit set.
- req_a  in  N_REQ*DIN0_WIDTH  packed operand A; slice i belongs to requester i.
- req_b  in  N_REQ*DIN1_WIDTH  packed operand B.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_id  out  ID_W  index of the requester that issued the result.
- rsp_data  out  DOUT_WIDTH  product.
- busy  out  1  high when either pipeline stage holds data.

## Operation
- Arbitration (combinational):
  - Round-robin over req_valid, starting from index ptr+1 mod N_REQ.
  - Exactly one grant exists when any req_valid bit is set.
  - req_ready[i] = grant[i] & s1_adv.
  - req_ready may depend combinationally on req_valid. Requesters must not derive req_valid from req_ready.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i].
  - On a transfer, ptr <= i.
  - Without a transfer, ptr holds, including while the pipeline is stalled.
- Stage 1 (S1): registers a, b, id and the s1_v flag.
- Stage 2 (S2): registers the product, id and s2_v. S2 drives rsp_*.
- Stall logic:
  - s2_adv = !s2_v | rsp_ready.
  - s1_adv = !s1_v | s2_adv.
  - S1 loads on s1_adv. s1_v <= (transfer occurred).
  - S2 loads on s2_adv. s2_v <= s1_v.
  - A stalled stage holds all of its contents.
- Arithmetic:
  - The full signed product is DIN0_WIDTH+DIN1_WIDTH bits.
  - rsp_data is its low DOUT_WIDTH bits, i.e. two's-complement wrap. No saturation, no rounding.
- busy = s1_v | s2_v.
- Ordering: results leave in grant order. No reordering and no drops.
- Reset (asynchronous assert, synchronous-safe release):
  - s1_v = s2_v = 0, so rsp_valid = 0 and busy = 0.
  - rsp_id = 0, rsp_data = 0.
  - ptr = N_REQ-1, so requester 0 wins first.
  - req_ready is 0 while ap_rst_n is low.
  - A mid-operation reset discards all in-flight results. No rsp is produced for them.

## Timing
- Latency: a transfer at edge k produces rsp_valid=1 in the cycle after edge k+1 (2 cycles) when rsp_ready is held high.
- Throughput: one result per cycle with continuous valid and rsp_ready=1.
- rsp_ready low with s2_v=1:
  - S2 holds.
  - S1 accepts one more pair only if it is empty, then holds.
  - Only after that does req_ready drop to 0.
- rsp_ready high again: S2 and S1 drain in order. req_ready reasserts in the same cycle.
- rsp_valid, rsp_id and rsp_data stay stable while rsp_valid & !rsp_ready.
- Simultaneous S2 output and S1 load in one cycle is allowed.
- Single requester continuously valid: it is granted every cycle (no forced idle).

## Test plan
- Reset release, then requester 0 sends a=-3, b=5 -> rsp_id=0 and rsp_data=0x3FFFFFF1 two cycles after the transfer. busy is 1 for those two cycles, then 0.
- Wrap check: a=b=0x1FFFF (131071) -> rsp_data=0x3FFC0001. a=b=-131072 -> rsp_data=0.
- All 4 requesters continuously valid, rsp_ready=1 -> grant order 0,1,2,3,0,1,… with one result per cycle. rsp_id follows the same sequence, offset by 2 cycles.
- Requesters 1 and 3 only, with rsp_ready held low for 5 cycles after the first transfer -> exactly 2 pairs accepted and req_ready=0 thereafter. After release, the results 1 then 3 appear and rsp_data stays stable during the stall.
- ap_rst_n pulsed low while both stages are valid -> rsp_valid and busy drop immediately. After release, no stale results appear and the first grant goes to requester 0.
- Random valid/rsp_ready traffic over 10k cycles, checked against a reference queue -> every accepted pair returns once, in order, with the correct id and wrapped product.
